ecdsa_hash_arbiter: RTL and testbench

ECDSA_HASH_ARBITER -- requirements
Module: ecdsa_hash_arbiter

---
 rtl/elliptic_curve_structs.sv | 22 ++
 rtl/ecdsa_hash_arbiter_if.sv | 33 +++
 rtl/ecdsa_hash_rr_pick.sv | 30 +++
 rtl/ecdsa_hash_arbiter.sv | 126 ++++++++++++
 tb/tb_ecdsa_hash_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/elliptic_curve_structs.sv
// ---------------------------------------------------------------------------
// elliptic_curve_structs : shared types for the ECDSA hash-core arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package elliptic_curve_structs;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } hash_arb_state_t;

   typedef enum logic {
      SIGN   = 1'b0,
      VERIFY = 1'b1
   } hash_requester_t;

endpackage

`default_nettype wire

// File: rtl/ecdsa_hash_arbiter_if.sv
// ---------------------------------------------------------------------------
// ecdsa_hash_arbiter_if : request/grant/strobe bundle between the sign and
// verify controllers, the shared hash core and the arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ecdsa_hash_arbiter_if;
   logic req_sign;
   logic req_verify;
   logic done_hash;
   logic start_hash;
   logic msg_sel;
   logic gnt_sign;
   logic gnt_verify;
   logic load_hash_sign;
   logic load_hash_verify;
   logic busy;
   logic hash_timeout;

   modport master (
      output req_sign, req_verify, done_hash,
      input  start_hash, msg_sel, gnt_sign, gnt_verify,
      input  load_hash_sign, load_hash_verify, busy, hash_timeout
   );

   modport slave (
      input  req_sign, req_verify, done_hash,
      output start_hash, msg_sel, gnt_sign, gnt_verify,
      output load_hash_sign, load_hash_verify, busy, hash_timeout
   );
endinterface

`default_nettype wire

// File: rtl/ecdsa_hash_rr_pick.sv
// ---------------------------------------------------------------------------
// ecdsa_hash_rr_pick : two-way round-robin pick between sign and verify
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ecdsa_hash_rr_pick
   import elliptic_curve_structs::*;
(
   input  logic            req_sign,
   input  logic            req_verify,
   input  hash_requester_t last_owner,
   output logic            valid,
   output hash_requester_t winner
);

   always_comb begin
      valid  = req_sign | req_verify;
      winner = SIGN;
      if (req_sign && req_verify) begin
         // On a tie the requester that did not go last wins.
         winner = (last_owner == SIGN) ? VERIFY : SIGN;
      end else if (req_verify) begin
         winner = VERIFY;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ecdsa_hash_arbiter.sv
// ---------------------------------------------------------------------------
// ecdsa_hash_arbiter : round-robin owner of the shared hash core for the sign
// and verify controllers. Optional WAIT abort: ECDSA_HASH_ARB_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ecdsa_hash_arbiter
   import elliptic_curve_structs::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   ecdsa_hash_arbiter_if.slave   bus
);

   hash_arb_state_t r_state;
   hash_requester_t r_owner;
   hash_requester_t r_last_owner;
   logic            r_start;
   logic            r_gnt_sign;
   logic            r_gnt_verify;
   logic            r_msg_sel;
   logic            r_busy;

   logic            w_valid;
   hash_requester_t w_winner;
   logic            w_done;
   logic            w_expire;

   ecdsa_hash_rr_pick u_pick (
      .req_sign   (bus.req_sign),
      .req_verify (bus.req_verify),
      .last_owner (r_last_owner),
      .valid      (w_valid),
      .winner     (w_winner)
   );

   assign w_done = (r_state == WAIT) && bus.done_hash;

`ifdef ECDSA_HASH_ARB_TIMEOUT_EN
   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // r_cnt holds the number of WAIT cycles already elapsed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == START) begin
         r_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

   assign w_expire = (r_state == WAIT) && (r_cnt == c_cnt_last) && !bus.done_hash;
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
   assign w_expire         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= SIGN;
         r_last_owner <= VERIFY;
         r_start      <= 1'b0;
         r_gnt_sign   <= 1'b0;
         r_gnt_verify <= 1'b0;
         r_msg_sel    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_owner      <= w_winner;
                  r_start      <= 1'b1;
                  r_gnt_sign   <= (w_winner == SIGN);
                  r_gnt_verify <= (w_winner == VERIFY);
                  r_msg_sel    <= (w_winner == VERIFY);
                  r_busy       <= 1'b1;
                  r_state      <= START;
               end
            end
            START: begin
               r_start <= 1'b0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_done || w_expire) begin
                  r_last_owner <= r_owner;
                  r_gnt_sign   <= 1'b0;
                  r_gnt_verify <= 1'b0;
                  r_msg_sel    <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_start      <= 1'b0;
               r_gnt_sign   <= 1'b0;
               r_gnt_verify <= 1'b0;
               r_msg_sel    <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   // Outputs are forced low while reset is held so an abandoned grant never leaks.
   assign bus.start_hash       = r_start      & ~reset;
   assign bus.gnt_sign         = r_gnt_sign   & ~reset;
   assign bus.gnt_verify       = r_gnt_verify & ~reset;
   assign bus.msg_sel          = r_msg_sel    & ~reset;
   assign bus.busy             = r_busy       & ~reset;
   assign bus.load_hash_sign   = w_done & (r_owner == SIGN)   & ~reset;
   assign bus.load_hash_verify = w_done & (r_owner == VERIFY) & ~reset;
   assign bus.hash_timeout     = w_expire & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_ecdsa_hash_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ecdsa_hash_arbiter : directed vector bench for ecdsa_hash_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ecdsa_hash_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ecdsa_hash_arbiter_if bus ();

   ecdsa_hash_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // expected bits: start, gnt_sign, gnt_verify, msg_sel, load_s, load_v, busy, timeout
   typedef struct packed {
      logic       rst;
      logic       rs;
      logic       rv;
      logic       d;
      logic [7:0] exp;
   } vec_t;

   localparam int c_nvec = 19;

   vec_t tbl [c_nvec];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [7:0] obs();
      return {bus.start_hash, bus.gnt_sign, bus.gnt_verify, bus.msg_sel,
              bus.load_hash_sign, bus.load_hash_verify, bus.busy, bus.hash_timeout};
   endfunction

   function automatic vec_t mk(logic rst, logic rs, logic rv, logic d, logic [7:0] exp);
      vec_t v;
      v.rst = rst; v.rs = rs; v.rv = rv; v.d = d; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, settle, leave sampling to caller.
   task automatic drive(input logic rst, input logic rs, input logic rv, input logic d);
      @(negedge clk);
      reset          = rst;
      bus.req_sign   = rs;
      bus.req_verify = rv;
      bus.done_hash  = d;
      #1;
   endtask

   initial begin
      logic       seen;
      logic [1:0] exp_g;
      int         budget;

      reset          = 1'b1;
      bus.req_sign   = 1'b0;
      bus.req_verify = 1'b0;
      bus.done_hash  = 1'b0;

      tbl[0]  = mk(1, 0, 0, 0, 8'b0000_0000);
      tbl[1]  = mk(0, 0, 0, 0, 8'b0000_0000);
      tbl[2]  = mk(0, 1, 0, 0, 8'b0000_0000);
      tbl[3]  = mk(0, 1, 0, 0, 8'b1100_0010);
      tbl[4]  = mk(0, 0, 0, 0, 8'b0100_0010);
      tbl[5]  = mk(0, 0, 0, 1, 8'b0100_1010);
      tbl[6]  = mk(0, 0, 0, 0, 8'b0000_0000);
      tbl[7]  = mk(0, 0, 1, 1, 8'b0000_0000);
      tbl[8]  = mk(0, 0, 1, 1, 8'b1011_0010);
      tbl[9]  = mk(0, 0, 0, 0, 8'b0011_0010);
      tbl[10] = mk(0, 0, 0, 1, 8'b0011_0110);
      tbl[11] = mk(0, 1, 1, 0, 8'b0000_0000);
      tbl[12] = mk(0, 1, 1, 0, 8'b1100_0010);
      tbl[13] = mk(0, 1, 1, 1, 8'b0100_1010);
      tbl[14] = mk(0, 1, 1, 0, 8'b0000_0000);
      tbl[15] = mk(0, 0, 1, 0, 8'b1011_0010);
      tbl[16] = mk(1, 0, 1, 1, 8'b0000_0000);
      tbl[17] = mk(0, 0, 0, 1, 8'b0000_0000);
      tbl[18] = mk(0, 0, 0, 0, 8'b0000_0000);

      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < c_nvec; i++) begin
         drive(tbl[i].rst, tbl[i].rs, tbl[i].rv, tbl[i].d);
         chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // Both requests held from reset: ownership alternates sign, verify, sign, verify.
      drive(1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         exp_g  = (k % 2 == 0) ? 2'b10 : 2'b01;
         seen   = 1'b0;
         budget = 0;
         while (!seen && budget < 10) begin
            drive(0, 1, 1, 0);
            seen = bus.start_hash;
            budget++;
         end
         chk($sformatf("rr%0d_start", k), {7'd0, seen}, 8'd1);
         chk($sformatf("rr%0d_gnt_sel", k), {5'd0, bus.gnt_sign, bus.gnt_verify, bus.msg_sel},
             {5'd0, exp_g, exp_g[0]});
         drive(0, 1, 1, 0);
         drive(0, 1, 1, 1);
         chk($sformatf("rr%0d_load", k), {6'd0, bus.load_hash_sign, bus.load_hash_verify},
             {6'd0, exp_g});
      end

      drive(1, 0, 0, 0);
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      chk("wait_entry_start", obs(), 8'b1100_0010);
`ifdef ECDSA_HASH_ARB_TIMEOUT_EN
      // No done: abort on the 8th WAIT cycle, then the pending verify is granted.
      for (int w = 1; w <= 8; w++) begin
         drive(0, 0, 1, 0);
         if (w < 8) chk($sformatf("to_wait%0d", w), obs(), 8'b0100_0010);
         else       chk("to_pulse", obs(), 8'b0100_0011);
      end
      drive(0, 0, 1, 0);
      chk("to_idle", obs(), 8'b0000_0000);
      drive(0, 0, 1, 0);
      chk("to_next_grant", obs(), 8'b1011_0010);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      chk("to_next_load", obs(), 8'b0011_0110);
`else
      // No done for 5000 cycles: the grant must simply persist.
      seen = 1'b0;
      for (int w = 0; w < 5000; w++) begin
         drive(0, 0, 0, 0);
         if (bus.hash_timeout !== 1'b0 || bus.gnt_sign !== 1'b1) seen = 1'b1;
      end
      chk("long_wait_no_abort", {7'd0, seen}, 8'd0);
      chk("long_wait_state", obs(), 8'b0100_0010);
      drive(0, 0, 0, 1);
      chk("long_wait_load", obs(), 8'b0100_1010);
`endif
      drive(0, 0, 0, 0);
      chk("final_idle", obs(), 8'b0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
